// File: rtl/echo_pkg.sv
// Shared echo-path types and helpers: FSM states, rounding constant and
// a width-parameterised saturation used by the lag generator and canceller.
package echo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    function automatic logic [63:0] round_const(input int unsigned coef_w);
        return 64'd1 << (coef_w - 2);
    endfunction

    // Clamp v into the signed range of a w-bit word.
    function automatic logic signed [63:0] sat(
        input logic signed [63:0] v,
        input int unsigned w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/echo_mac_unit.sv
// Signed DATA_W x COEF_W multiply-accumulate into an ACC_W register
// with synchronous clear and accumulate enable.
module echo_mac_unit #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int ACC_W  = 36
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     acc_en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [COEF_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    logic signed [DATA_W+COEF_W-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/lag_generator_param.sv
// Time-multiplexed FIR echo generator with double-buffered coefficients.
// Define LAG_GENERATOR_SAT_EN to saturate the output instead of wrapping.
module lag_generator_param
    import echo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int TAPS   = 16,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                      clk_operation,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [DATA_W-1:0]         signal,
    input  logic                      coef_wr_en,
    input  logic [$clog2(TAPS)-1:0]   coef_wr_addr,
    input  logic [COEF_W-1:0]         coef_wr_data,
    output logic [DATA_W-1:0]         signal_lag,
    output logic [DATA_W-1:0]         signal_align,
    output logic                      ready,
    output logic                      busy,
    output logic                      overrun
);

    localparam int AW = $clog2(TAPS);
    localparam logic signed [ACC_W:0] RND =
        (ACC_W + 1)'(round_const(COEF_W));

    logic signed [DATA_W-1:0] hist   [TAPS];
    logic signed [COEF_W-1:0] shadow [TAPS];
    logic signed [COEF_W-1:0] active [TAPS];

    state_t                   state;
    state_t                   state_nxt;
    logic [AW-1:0]            idx;
    logic                     accept;
    logic                     acc_en;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W:0]    sum;
    logic signed [ACC_W:0]    r;
    logic [DATA_W-1:0]        lag_nxt;

    assign accept = enable && (state == IDLE);
    assign acc_en = (state == MAC);

    echo_mac_unit #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (clk_operation),
        .rst    (rst),
        .clr    (accept),
        .acc_en (acc_en),
        .a      (hist[idx]),
        .b      (active[idx]),
        .acc    (acc)
    );

    assign sum = {acc[ACC_W-1], acc} + RND;
    assign r   = sum >>> (COEF_W - 1);

`ifdef LAG_GENERATOR_SAT_EN
    assign lag_nxt = DATA_W'(sat(64'(r), DATA_W));
`else
    assign lag_nxt = r[DATA_W-1:0];
`endif

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (enable) state_nxt = MAC;
            MAC:     if (idx == AW'(TAPS - 1)) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_operation) begin
        if (rst) begin
            for (int k = 0; k < TAPS; k++) begin
                hist[k]   <= '0;
                shadow[k] <= '0;
                active[k] <= '0;
            end
            state        <= IDLE;
            idx          <= '0;
            signal_lag   <= '0;
            signal_align <= '0;
            ready        <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state <= state_nxt;
            ready <= 1'b0;
            if (coef_wr_en && (int'(coef_wr_addr) < TAPS)) begin
                shadow[coef_wr_addr] <= coef_wr_data;
            end
            if (enable && busy) begin
                overrun <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (enable) begin
                        hist[0] <= signal;
                        for (int k = 1; k < TAPS; k++) begin
                            hist[k] <= hist[k-1];
                        end
                        // Write-first: a same-edge write lands in this copy.
                        for (int k = 0; k < TAPS; k++) begin
                            if (coef_wr_en && (int'(coef_wr_addr) == k)) begin
                                active[k] <= coef_wr_data;
                            end else begin
                                active[k] <= shadow[k];
                            end
                        end
                        signal_align <= signal;
                        idx          <= '0;
                        busy         <= 1'b1;
                    end
                end
                MAC: begin
                    idx <= idx + 1'b1;
                end
                OUT: begin
                    signal_lag <= lag_nxt;
                    ready      <= 1'b1;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lag_generator_param.sv
// Scoreboard bench for lag_generator_param, TAPS=4, 16-bit data and coefs.
// Honours LAG_GENERATOR_SAT_EN for the expected overflow behaviour.
module tb_lag_generator_param;

    localparam int DATA_W = 16;
    localparam int COEF_W = 16;
    localparam int TAPS   = 4;

    logic              clk_operation = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic [15:0]       signal = '0;
    logic              coef_wr_en = 1'b0;
    logic [1:0]        coef_wr_addr = '0;
    logic [15:0]       coef_wr_data = '0;
    logic [15:0]       signal_lag;
    logic [15:0]       signal_align;
    logic              ready;
    logic              busy;
    logic              overrun;

    typedef struct {
        logic [15:0] lag;
        logic [15:0] align;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    lag_generator_param #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .TAPS   (TAPS)
    ) dut (
        .clk_operation (clk_operation),
        .rst           (rst),
        .enable        (enable),
        .signal        (signal),
        .coef_wr_en    (coef_wr_en),
        .coef_wr_addr  (coef_wr_addr),
        .coef_wr_data  (coef_wr_data),
        .signal_lag    (signal_lag),
        .signal_align  (signal_align),
        .ready         (ready),
        .busy          (busy),
        .overrun       (overrun)
    );

    always #5 clk_operation = ~clk_operation;

    task automatic tick();
        @(posedge clk_operation);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic write_coef(input logic [1:0] a, input logic [15:0] d);
        coef_wr_en   = 1'b1;
        coef_wr_addr = a;
        coef_wr_data = d;
        tick();
        coef_wr_en = 1'b0;
    endtask

    task automatic drive(input logic [15:0] v, input logic [15:0] lag);
        exp_t e;
        e.lag   = lag;
        e.align = v;
        q.push_back(e);
        enable = 1'b1;
        signal = v;
        tick();
        enable = 1'b0;
    endtask

    task automatic collect(
        input  int          budget,
        output int          lat,
        output logic [15:0] lag,
        output logic [15:0] al
    );
        lat = -1;
        lag = 'x;
        al  = 'x;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (ready) begin
                lat = i;
                lag = signal_lag;
                al  = signal_align;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (signal_lag !== 16'd0 || signal_align !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: lag=%0h align=%0h want 0 0",
                     signal_lag, signal_align);
        end
        checks++;
        if ({ready, busy, overrun} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: rdy/busy/ovr=%b want 000",
                     {ready, busy, overrun});
        end
    endtask

    task automatic test_single();
        int lat;
        logic [15:0] lag, al;
        exp_t e;
        do_reset();
        write_coef(2'd0, 16'h4000);
        drive(16'd1000, 16'd500);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy: busy=%b want 1", busy);
        end
        collect(10, lat, lag, al);
        e = q.pop_front();
        checks++;
        if (lat != 5) begin
            errors++;
            $display("FAIL single_latency: got %0d want 5", lat);
        end
        checks++;
        if (lag !== e.lag || al !== e.align) begin
            errors++;
            $display("FAIL single_out: lag=%0d align=%0d want %0d %0d",
                     lag, al, e.lag, e.align);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_ready: busy=%b want 0", busy);
        end
        tick();
        checks++;
        if (ready !== 1'b0 || signal_lag !== 16'd500) begin
            errors++;
            $display("FAIL single_hold: rdy=%b lag=%0d want 0 500",
                     ready, signal_lag);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [15:0] lag, al;
        exp_t e;
        do_reset();
        write_coef(2'd0, 16'h4000);
        drive(16'd1000, 16'd500);
        collect(10, lat, lag, al);
        e = q.pop_front();
        drive(16'd2000, 16'd1000);
        collect(10, lat, lag, al);
        e = q.pop_front();
        checks++;
        if (lat != 5 || lag !== e.lag || al !== e.align) begin
            errors++;
            $display("FAIL b2b: lat=%0d lag=%0d align=%0d want 5 %0d %0d",
                     lat, lag, al, e.lag, e.align);
        end
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_overrun: got %b want 0", overrun);
        end
    endtask

    task automatic test_taps();
        int lat;
        logic [15:0] lag, al;
        logic [15:0] xs [3];
        logic [15:0] ys [3];
        exp_t e;
        xs[0] = 16'd1000; xs[1] = 16'd0; xs[2] = 16'd0;
        ys[0] = 16'd0;    ys[1] = 16'd0; ys[2] = 16'd1000;
        do_reset();
        write_coef(2'd2, 16'h7FFF);
        for (int i = 0; i < 3; i++) begin
            drive(xs[i], ys[i]);
            collect(10, lat, lag, al);
            e = q.pop_front();
            checks++;
            if (lag !== e.lag || al !== e.align) begin
                errors++;
                $display("FAIL taps_%0d: lag=%0d align=%0d want %0d %0d",
                         i, lag, al, e.lag, e.align);
            end
        end
    endtask

    task automatic test_overflow();
        int lat;
        logic [15:0] lag, al;
        logic [15:0] ys [4];
        exp_t e;
`ifdef LAG_GENERATOR_SAT_EN
        ys[0] = 16'd32766; ys[1] = 16'h7FFF;
        ys[2] = 16'h7FFF;  ys[3] = 16'h7FFF;
`else
        ys[0] = 16'd32766; ys[1] = 16'hFFFC;
        ys[2] = 16'h7FFA;  ys[3] = 16'hFFF8;
`endif
        do_reset();
        for (int k = 0; k < 4; k++) write_coef(2'(k), 16'h7FFF);
        for (int i = 0; i < 4; i++) begin
            drive(16'd32767, ys[i]);
            collect(10, lat, lag, al);
            e = q.pop_front();
            checks++;
            if (lag !== e.lag || al !== e.align) begin
                errors++;
                $display("FAIL ovf_%0d: lag=%0h align=%0h want %0h %0h",
                         i, lag, al, e.lag, e.align);
            end
        end
    endtask

    task automatic test_overrun();
        int lat;
        int extra;
        logic [15:0] lag, al;
        exp_t e;
        do_reset();
        write_coef(2'd0, 16'h4000);
        write_coef(2'd1, 16'h4000);
        drive(16'd1000, 16'd500);
        tick();
        enable = 1'b1;
        signal = 16'd3000;
        tick();
        enable = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got %b want 1", overrun);
        end
        collect(10, lat, lag, al);
        e = q.pop_front();
        checks++;
        if (lat != 3 || lag !== e.lag || al !== e.align) begin
            errors++;
            $display("FAIL overrun_out: lat=%0d lag=%0d al=%0d want 3 %0d %0d",
                     lat, lag, al, e.lag, e.align);
        end
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ready) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL overrun_pulses: extra=%0d want 0", extra);
        end
        drive(16'd2000, 16'd1500);
        collect(10, lat, lag, al);
        e = q.pop_front();
        checks++;
        if (lag !== e.lag || al !== e.align || overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_next: lag=%0d al=%0d ovr=%b want %0d %0d 1",
                     lag, al, overrun, e.lag, e.align);
        end
    endtask

    task automatic test_coef_update();
        int lat;
        logic [15:0] lag, al;
        exp_t e;
        do_reset();
        write_coef(2'd0, 16'h4000);
        drive(16'd800, 16'd400);
        write_coef(2'd0, 16'h2000);
        collect(10, lat, lag, al);
        e = q.pop_front();
        checks++;
        if (lag !== e.lag || al !== e.align) begin
            errors++;
            $display("FAIL coef_old: lag=%0d align=%0d want %0d %0d",
                     lag, al, e.lag, e.align);
        end
        drive(16'd800, 16'd200);
        collect(10, lat, lag, al);
        e = q.pop_front();
        checks++;
        if (lag !== e.lag || al !== e.align) begin
            errors++;
            $display("FAIL coef_new: lag=%0d align=%0d want %0d %0d",
                     lag, al, e.lag, e.align);
        end
    endtask

    task automatic test_rst_mid();
        int lat;
        int seen;
        logic [15:0] lag, al;
        exp_t e;
        do_reset();
        write_coef(2'd0, 16'h4000);
        enable = 1'b1;
        signal = 16'd1000;
        tick();
        enable = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (ready) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_mid_ready: pulses=%0d want 0", seen);
        end
        checks++;
        if (signal_lag !== 16'd0 || signal_align !== 16'd0 ||
            busy !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_outs: lag=%0d al=%0d busy=%b ovr=%b want 0",
                     signal_lag, signal_align, busy, overrun);
        end
        write_coef(2'd1, 16'h7FFF);
        drive(16'd1000, 16'd0);
        collect(10, lat, lag, al);
        e = q.pop_front();
        checks++;
        if (lat != 5 || lag !== e.lag || al !== e.align) begin
            errors++;
            $display("FAIL rst_mid_hist: lat=%0d lag=%0d al=%0d want 5 %0d %0d",
                     lat, lag, al, e.lag, e.align);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_taps();
        test_overflow();
        test_overrun();
        test_coef_update();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
